// File: rtl/data_length_packer_if.sv
// Write-side request bus and read-side FIFO handshake of the data length packer.
// The producer uses the master modport and the packer uses the slave modport.
interface data_length_packer_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
);
  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              HWriteReg;
  logic [DATA_W-1:0] HWDATA;
  logic [OFF_W-1:0]  HADDR_LO;
  logic [3:0]        SIGNAL_LENGTH;
  logic [1:0]        FILL_MODE;
  logic              in_ready;

  logic [DATA_W-1:0] PWDATA;
  logic [STRB_W-1:0] PSTRB;
  logic              out_valid;
  logic              out_ready;

  logic [CNT_W-1:0]  count;
  logic              err_overflow;
  logic              err_misalign;

  modport master (
    output HWriteReg, HWDATA, HADDR_LO, SIGNAL_LENGTH, FILL_MODE, out_ready,
    input  in_ready, PWDATA, PSTRB, out_valid, count, err_overflow, err_misalign
  );

  modport slave (
    input  HWriteReg, HWDATA, HADDR_LO, SIGNAL_LENGTH, FILL_MODE, out_ready,
    output in_ready, PWDATA, PSTRB, out_valid, count, err_overflow, err_misalign
  );
endinterface

// File: rtl/data_length_packer.sv
// Extracts an 8/16/32/64-bit field from a write word, fills the upper bits and
// queues the formatted word with its byte strobes in a small FIFO.
module data_length_packer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                HCLK,
  input  logic                HRESET,
  data_length_packer_if.slave bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [3:0] LEN_8  = 4'b0001;
  localparam logic [3:0] LEN_16 = 4'b0010;
  localparam logic [3:0] LEN_32 = 4'b0100;
  localparam logic [3:0] LEN_64 = 4'b1000;

  typedef enum logic [1:0] {
    FILL_ONES     = 2'b00,
    FILL_ZEROS    = 2'b01,
    FILL_SIGN     = 2'b10,
    FILL_ONES_ALT = 2'b11
  } fill_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Request formatting
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] field_mask;
  logic [DATA_W-1:0] fill_bits;
  entry_t            fmt_entry;
  logic              legal;
  logic              sign_bit;

  // NOTE: every variable of a combinational block gets a default before any
  // branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    // An aligned field starts at bit 8*offset for every legal length.
    shifted    = bus.HWDATA >> {bus.HADDR_LO, 3'b000};
    field_mask = '0;
    fill_bits  = '1;
    fmt_entry  = '0;
    legal      = 1'b0;
    sign_bit   = 1'b0;

    case (bus.SIGNAL_LENGTH)
      LEN_8: begin
        legal          = 1'b1;
        field_mask     = DATA_W'(8'hFF);
        fmt_entry.strb = STRB_W'(1'b1);
        sign_bit       = shifted[7];
      end
      LEN_16: begin
        legal          = (bus.HADDR_LO[0] == 1'b0);
        field_mask     = DATA_W'(16'hFFFF);
        fmt_entry.strb = STRB_W'(2'b11);
        sign_bit       = shifted[15];
      end
      LEN_32: begin
        legal          = (bus.HADDR_LO[1:0] == 2'b00);
        field_mask     = DATA_W'(32'hFFFF_FFFF);
        fmt_entry.strb = STRB_W'(4'b1111);
        sign_bit       = shifted[31];
      end
      LEN_64: begin
        legal          = (DATA_W == 64) && (bus.HADDR_LO == '0);
        field_mask     = '1;
        fmt_entry.strb = '1;
        sign_bit       = shifted[DATA_W-1];
      end
      default: ;
    endcase

    case (fill_e'(bus.FILL_MODE))
      FILL_ZEROS: fill_bits = '0;
      FILL_SIGN:  fill_bits = {DATA_W{sign_bit}};
      default:    fill_bits = '1;
    endcase

    fmt_entry.data = (shifted & field_mask) | (fill_bits & ~field_mask);
  end

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             err_overflow_q;
  logic             err_misalign_q;
  logic             full;
  logic             not_empty;
  logic             push;
  logic             pop;

  // Full is judged on the registered count only, so a pop on the same edge
  // never makes room for a push.
  assign full      = (count_q == CNT_W'(DEPTH));
  assign not_empty = (count_q != '0);
  assign push      = bus.HWriteReg && !full && legal;
  assign pop       = not_empty && bus.out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count_q        <= '0;
      err_overflow_q <= 1'b0;
      err_misalign_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase

      // A write refused for fullness reports only the overflow.
      if (bus.HWriteReg && full)
        err_overflow_q <= 1'b1;
      else if (bus.HWriteReg && !legal)
        err_misalign_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Entry storage
  // ---------------------------------------------------------------------------
  entry_t mem [DEPTH];

  // NOTE: the storage array has no reset; a slot is only ever read after it
  // has been written, and the output mux hides it while the FIFO is empty.
  always_ff @(posedge HCLK) begin
    if (push) mem[wr_ptr] <= fmt_entry;
  end

  assign bus.PWDATA       = not_empty ? mem[rd_ptr].data : '0;
  assign bus.PSTRB        = not_empty ? mem[rd_ptr].strb : '0;
  assign bus.out_valid    = not_empty;
  assign bus.in_ready     = !full;
  assign bus.count        = count_q;
  assign bus.err_overflow = err_overflow_q;
  assign bus.err_misalign = err_misalign_q;

endmodule

// File: tb/tb_data_length_packer.sv
// Bench for data_length_packer: a 32-bit and a 64-bit instance are compared each
// cycle against a queue-based reference model, with directed and random writes.
module tb_data_length_packer;
  localparam int DEPTH = 4;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  s;
  } entry_t;

  logic HCLK = 1'b0;
  logic HRESET;

  always #5 HCLK = ~HCLK;

  data_length_packer_if #(.DATA_W(32), .DEPTH(DEPTH)) ia ();
  data_length_packer_if #(.DATA_W(64), .DEPTH(DEPTH)) ib ();

  data_length_packer #(.DATA_W(32), .DEPTH(DEPTH)) dut_a (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (ia.slave)
  );

  data_length_packer #(.DATA_W(64), .DEPTH(DEPTH)) dut_b (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (ib.slave)
  );

  int     n_checks = 0;
  int     n_fail   = 0;
  entry_t q_a[$];
  entry_t q_b[$];
  bit     eovf[2];
  bit     emis[2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference formatting straight from the length/offset/fill rules.
  function automatic void fmt(input int dw, input logic [63:0] data, input int off,
                              input logic [3:0] len, input logic [1:0] fill,
                              output bit legal, output logic [63:0] fd, output logic [7:0] fs);
    int          nbytes;
    logic [63:0] field;
    logic [63:0] ones;
    logic [63:0] upper;
    case (len)
      4'd1:    nbytes = 1;
      4'd2:    nbytes = 2;
      4'd4:    nbytes = 4;
      4'd8:    nbytes = 8;
      default: nbytes = 0;
    endcase
    legal = (nbytes != 0) && (nbytes <= dw / 8) && (off % nbytes == 0);
    fd = '0;
    fs = '0;
    if (!legal) return;
    field = data >> (8 * off);
    ones  = (nbytes == 8) ? '1 : ((64'd1 << (8 * nbytes)) - 64'd1);
    field = field & ones;
    if (fill == 2'b01)      upper = '0;
    else if (fill == 2'b10) upper = field[8*nbytes-1] ? ~ones : '0;
    else                    upper = ~ones;
    fd = field | upper;
    if (dw == 32) fd = fd & 64'h0000_0000_FFFF_FFFF;
    fs = 8'((1 << nbytes) - 1);
  endfunction

  task automatic model_step(input int d, input int dw, input logic wr, input logic [63:0] data,
                            input int off, input logic [3:0] len, input logic [1:0] fill,
                            input logic ordy);
    int          n;
    bit          legal;
    logic [63:0] fd;
    logic [7:0]  fs;
    entry_t      e;
    if (HRESET) begin
      if (d == 0) q_a.delete(); else q_b.delete();
      eovf[d] = 1'b0;
      emis[d] = 1'b0;
      return;
    end
    n = (d == 0) ? q_a.size() : q_b.size();
    fmt(dw, data, off, len, fill, legal, fd, fs);
    e.d = fd;
    e.s = fs;
    if (wr) begin
      if (n == DEPTH) eovf[d] = 1'b1;
      else if (!legal) emis[d] = 1'b1;
    end
    if (n > 0 && ordy) begin
      if (d == 0) void'(q_a.pop_front()); else void'(q_b.pop_front());
    end
    if (wr && n < DEPTH && legal) begin
      if (d == 0) q_a.push_back(e); else q_b.push_back(e);
    end
  endtask

  task automatic check_dut(input string p, input int d, input logic [63:0] cnt,
                           input logic [63:0] valid, input logic [63:0] rdy,
                           input logic [63:0] data, input logic [63:0] strb,
                           input logic [63:0] eo, input logic [63:0] em);
    int     n;
    entry_t h;
    n   = (d == 0) ? q_a.size() : q_b.size();
    h.d = '0;
    h.s = '0;
    if (n > 0) h = (d == 0) ? q_a[0] : q_b[0];
    check({p, "_count"},        cnt,   64'(n));
    check({p, "_out_valid"},    valid, 64'(n > 0));
    check({p, "_in_ready"},     rdy,   64'(n < DEPTH));
    check({p, "_PWDATA"},       data,  h.d);
    check({p, "_PSTRB"},        strb,  64'(h.s));
    check({p, "_err_overflow"}, eo,    64'(eovf[d]));
    check({p, "_err_misalign"}, em,    64'(emis[d]));
  endtask

  task automatic tick();
    model_step(0, 32, ia.HWriteReg, {32'd0, ia.HWDATA}, int'(ia.HADDR_LO),
               ia.SIGNAL_LENGTH, ia.FILL_MODE, ia.out_ready);
    model_step(1, 64, ib.HWriteReg, ib.HWDATA, int'(ib.HADDR_LO),
               ib.SIGNAL_LENGTH, ib.FILL_MODE, ib.out_ready);
    @(posedge HCLK);
    #1;
    check_dut("a", 0, 64'(ia.count), 64'(ia.out_valid), 64'(ia.in_ready), 64'(ia.PWDATA),
              64'(ia.PSTRB), 64'(ia.err_overflow), 64'(ia.err_misalign));
    check_dut("b", 1, 64'(ib.count), 64'(ib.out_valid), 64'(ib.in_ready), 64'(ib.PWDATA),
              64'(ib.PSTRB), 64'(ib.err_overflow), 64'(ib.err_misalign));
  endtask

  task automatic drive_a(input logic wr, input logic [31:0] data, input logic [1:0] off,
                         input logic [3:0] len, input logic [1:0] fill, input logic ordy);
    ia.HWriteReg     = wr;
    ia.HWDATA        = data;
    ia.HADDR_LO      = off;
    ia.SIGNAL_LENGTH = len;
    ia.FILL_MODE     = fill;
    ia.out_ready     = ordy;
  endtask

  task automatic drive_b(input logic wr, input logic [63:0] data, input logic [2:0] off,
                         input logic [3:0] len, input logic [1:0] fill, input logic ordy);
    ib.HWriteReg     = wr;
    ib.HWDATA        = data;
    ib.HADDR_LO      = off;
    ib.SIGNAL_LENGTH = len;
    ib.FILL_MODE     = fill;
    ib.out_ready     = ordy;
  endtask

  logic [31:0] vals [5];
  logic [3:0]  lens [4];

  initial begin
    vals = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004, 32'h5555_0005};
    lens = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    // Reset state
    HRESET = 1'b1;
    drive_a(1'b0, '0, '0, 4'b0001, 2'b00, 1'b0);
    drive_b(1'b0, '0, '0, 4'b0001, 2'b00, 1'b0);
    tick();
    tick();
    HRESET = 1'b0;
    check("reset_in_ready", 64'(ia.in_ready), 64'd1);
    check("reset_PWDATA",   64'(ia.PWDATA),   64'd0);

    // 8-bit sign extend from byte 2
    drive_a(1'b1, 32'hA1B2_C3D4, 2'd2, 4'b0001, 2'b10, 1'b0);
    tick();
    check("byte_sext_data",  64'(ia.PWDATA),    64'hFFFF_FFB2);
    check("byte_sext_strb",  64'(ia.PSTRB),     64'h1);
    check("byte_sext_valid", 64'(ia.out_valid), 64'd1);
    drive_a(1'b0, '0, '0, 4'b0001, 2'b00, 1'b1);
    tick();

    // 16-bit zero fill, then misaligned halfword
    drive_a(1'b1, 32'h1234_8765, 2'd0, 4'b0010, 2'b01, 1'b0);
    tick();
    check("half_zero_data", 64'(ia.PWDATA), 64'h0000_8765);
    check("half_zero_strb", 64'(ia.PSTRB),  64'h3);
    drive_a(1'b1, 32'h1234_8765, 2'd1, 4'b0010, 2'b01, 1'b0);
    tick();
    check("half_misalign_count", 64'(ia.count),        64'd1);
    check("half_misalign_err",   64'(ia.err_misalign), 64'd1);
    drive_a(1'b0, '0, '0, 4'b0001, 2'b00, 1'b1);
    tick();

    // Overflow: five writes into a depth-4 FIFO, then ordered drain
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_a(1'b1, vals[i], 2'd0, 4'b0100, 2'b00, 1'b0);
      tick();
    end
    check("ovf_count",    64'(ia.count),        64'd4);
    check("ovf_in_ready", 64'(ia.in_ready),     64'd0);
    check("ovf_err",      64'(ia.err_overflow), 64'd1);
    for (int i = 0; i < 4; i++) begin
      check("ovf_drain_order", 64'(ia.PWDATA), 64'(vals[i]));
      drive_a(1'b0, '0, '0, 4'b0001, 2'b00, 1'b1);
      tick();
    end

    // Simultaneous push/pop at count 2 and at full
    drive_a(1'b1, 32'hA0, 2'd0, 4'b0100, 2'b00, 1'b0); tick();
    drive_a(1'b1, 32'hA1, 2'd0, 4'b0100, 2'b00, 1'b0); tick();
    drive_a(1'b1, 32'hA2, 2'd0, 4'b0100, 2'b00, 1'b1); tick();
    check("pp_mid_count", 64'(ia.count),  64'd2);
    check("pp_mid_head",  64'(ia.PWDATA), 64'hA1);
    drive_a(1'b1, 32'hA3, 2'd0, 4'b0100, 2'b00, 1'b0); tick();
    drive_a(1'b1, 32'hA4, 2'd0, 4'b0100, 2'b00, 1'b0); tick();
    drive_a(1'b1, 32'hA5, 2'd0, 4'b0100, 2'b00, 1'b1); tick();
    check("pp_full_count", 64'(ia.count),  64'd3);
    check("pp_full_head",  64'(ia.PWDATA), 64'hA2);
    for (int i = 2; i < 5; i++) begin
      check("pp_drain_order", 64'(ia.PWDATA), 64'hA0 + 64'(i));
      drive_a(1'b0, '0, '0, 4'b0001, 2'b00, 1'b1);
      tick();
    end
    check("pp_drained", 64'(ia.out_valid), 64'd0);

    // Reset while holding three entries and both errors
    for (int i = 0; i < 5; i++) begin
      drive_a(1'b1, vals[i], 2'd0, 4'b0100, 2'b00, 1'b0);
      tick();
    end
    drive_a(1'b0, '0, '0, 4'b0001, 2'b00, 1'b1); tick();
    drive_a(1'b1, 32'h0, 2'd0, 4'b0011, 2'b00, 1'b0); tick();
    check("pre_rst_count", 64'(ia.count),        64'd3);
    check("pre_rst_ovf",   64'(ia.err_overflow), 64'd1);
    check("pre_rst_mis",   64'(ia.err_misalign), 64'd1);
    HRESET = 1'b1;
    drive_a(1'b1, 32'hDEAD_BEEF, 2'd0, 4'b0100, 2'b00, 1'b1);
    tick();
    HRESET = 1'b0;
    check("rst_count",    64'(ia.count),        64'd0);
    check("rst_valid",    64'(ia.out_valid),    64'd0);
    check("rst_in_ready", 64'(ia.in_ready),     64'd1);
    check("rst_PWDATA",   64'(ia.PWDATA),       64'd0);
    check("rst_PSTRB",    64'(ia.PSTRB),        64'd0);
    check("rst_ovf",      64'(ia.err_overflow), 64'd0);
    check("rst_mis",      64'(ia.err_misalign), 64'd0);
    drive_a(1'b0, '0, '0, 4'b0001, 2'b00, 1'b0);

    // 64-bit instance: upper word with ones fill, then full doubleword
    drive_b(1'b1, 64'h1122_3344_5566_7788, 3'd4, 4'b0100, 2'b00, 1'b0);
    tick();
    check("w64_word_data", ib.PWDATA,       64'hFFFF_FFFF_1122_3344);
    check("w64_word_strb", 64'(ib.PSTRB),   64'h0F);
    drive_b(1'b1, 64'h8877_6655_4433_2211, 3'd0, 4'b1000, 2'b01, 1'b1);
    tick();
    check("w64_dword_data", ib.PWDATA,     64'h8877_6655_4433_2211);
    check("w64_dword_strb", 64'(ib.PSTRB), 64'hFF);
    drive_b(1'b0, '0, '0, 4'b0001, 2'b00, 1'b1);
    tick();

    // Random traffic on both instances
    for (int c = 0; c < 600; c++) begin
      logic [3:0] la, lb;
      la = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : lens[$urandom_range(0, 3)];
      lb = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : lens[$urandom_range(0, 3)];
      HRESET = ($urandom_range(0, 99) == 0);
      drive_a(1'($urandom_range(0, 9) < 6), $urandom, 2'($urandom_range(0, 3)), la,
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      drive_b(1'($urandom_range(0, 9) < 6), {$urandom, $urandom}, 3'($urandom_range(0, 7)), lb,
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      tick();
    end
    HRESET = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_length_packer.md
DATA_LENGTH_PACKER -- requirements
Module: data_length_packer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning data path width in bits (legal: 32 or 64).
REQ-002 SHALL have parameter DEPTH, default 4, meaning formatted-entry FIFO depth (power of 2, >=2).
REQ-003 SHALL have port HCLK  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port HRESET  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port HWriteReg  input  1  write request; sampled each HCLK edge.
REQ-006 SHALL have port HWDATA  input  DATA_W  raw write data.
REQ-007 SHALL have port HADDR_LO  input  log2(DATA_W/8)  byte offset of the transfer within the word.
REQ-008 SHALL have port SIGNAL_LENGTH  input  4  one-hot length: 0001=8b, 0010=16b, 0100=32b, 1000=64b.
REQ-009 SHALL have port FILL_MODE  input  2  fill for unused upper bits: 00=ones, 01=zeros, 10=sign-extend, 11=ones.
REQ-010 SHALL have port in_ready  output  1  FIFO not full.
REQ-011 SHALL have port PWDATA  output  DATA_W  formatted data at FIFO head.
REQ-012 SHALL have port PSTRB  output  DATA_W/8  byte strobes at FIFO head.
REQ-013 SHALL have port out_valid  output  1  FIFO not empty.
REQ-014 SHALL have port out_ready  input  1  consumer accepts head entry.
REQ-015 SHALL have port count  output  log2(DEPTH)+1  current number of stored entries.
REQ-016 SHALL have port err_overflow  output  1  sticky: write dropped because FIFO full.
REQ-017 SHALL have port err_misalign  output  1  sticky: write dropped because of misaligned offset or illegal length.

Function
REQ-018 SHALL push one formatted entry when HWriteReg=1, in_ready=1 and the request is legal.
REQ-019 SHALL pop the head entry when out_valid=1 and out_ready=1.
REQ-020 SHALL present a pushed entry on PWDATA/PSTRB with out_valid=1 on the first edge after push when the FIFO was empty (latency 1); no combinational input-to-output path.
REQ-021 SHALL, for 8b, take byte HWDATA[8*off+:8] into PWDATA[7:0], set PSTRB=...0001, and fill bits above 7 per FILL_MODE.
REQ-022 SHALL, for 16b, take HWDATA[16*(off/2)+:16] into PWDATA[15:0], set PSTRB=...0011, and fill bits above 15 per FILL_MODE.
REQ-023 SHALL, for 32b, take HWDATA[32*(off/4)+:32] into PWDATA[31:0], set PSTRB low four bits = 1111, and fill bits above 31 per FILL_MODE (DATA_W=64 only).
REQ-024 SHALL, for 64b (DATA_W=64 only), pass HWDATA unchanged with PSTRB all ones.
REQ-025 SHALL, in sign-extend mode, replicate the top bit of the extracted field into all fill bits.
REQ-026 SHALL treat a request as misaligned when off is not a multiple of the length in bytes, or when SIGNAL_LENGTH is non-one-hot, zero, or 1000 with DATA_W=32; such a request is dropped and sets err_misalign.
REQ-027 SHALL drop HWriteReg=1 while in_ready=0 and set err_overflow; when both errors apply, SHALL set only err_overflow.
REQ-028 SHALL, on simultaneous push and pop with 0<count<DEPTH, keep count unchanged and preserve order.
REQ-029 SHALL NOT accept a push when full, even if a pop occurs on the same edge (in_ready depends only on count).
REQ-030 SHALL drive PWDATA=0 and PSTRB=0 whenever out_valid=0.
REQ-031 SHALL wrap read and write pointers modulo DEPTH; count SHALL never exceed DEPTH or go below 0.

Reset
REQ-032 SHALL, on HCLK edge with HRESET=1, set count=0, out_valid=0, in_ready=1, PWDATA=0, PSTRB=0, err_overflow=0, err_misalign=0, and clear pointers.
REQ-033 SHALL give reset priority over simultaneous push/pop; entries in flight are discarded.
REQ-034 SHALL clear the sticky error flags only by reset.

Verification
REQ-035 SHALL verify: DATA_W=32, write HWDATA=0xA1B2C3D4, off=2, len=0001, fill=10 -> next cycle PWDATA=0xFFFFFFB2, PSTRB=0001, out_valid=1.
REQ-036 SHALL verify: len=0010, off=0, fill=01, HWDATA=0x12348765 -> PWDATA=0x00008765, PSTRB=0011; same with off=1 -> no push, err_misalign=1.
REQ-037 SHALL verify: DEPTH=4, five writes with out_ready=0 -> count=4, in_ready=0, err_overflow=1, then four pops return the first four entries in order.
REQ-038 SHALL verify: count=2, push and pop on the same edge -> count stays 2 and order is preserved; at count=4, push plus pop -> count=3 and the push is dropped.
REQ-039 SHALL verify: HRESET=1 asserted with count=3 and both errors set -> next edge all outputs are at reset values and in_ready=1.
REQ-040 SHALL verify: DATA_W=64, len=0100, off=4, fill=00, HWDATA=0x11223344_55667788 -> PWDATA=0xFFFFFFFF_11223344, PSTRB=0x0F.
